hand_score_accumulator: RTL
===========================

Name: hand_score_accumulator

Overview:
- Sequential, parametrised successor to the combinational three-card hand scorer.
- Takes one card per valid/ready handshake into a hand of up to MAX_CARDS cards.
- Keeps a registered running total reduced modulo MOD.
- Reports card count, hand state, a "natural" flag and invalid-card errors to the game datapath/controller, which reads totals without re-summing raw cards.

Parameters:
- MAX_CARDS, 3, maximum cards per hand (>=2).
- CARD_W, 4, card code width in bits.
- MOD, 10, modulus applied to the total (>=2, <=2^CARD_W).
- FACE_MIN, 11, lowest rank code scored as a face card.
- FACE_MAX, 13, highest valid rank code.
- FACE_VAL, 0, score value of a face card (must be <MOD).
- NAT_MIN, 8, two-card total at or above which natural asserts.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous hand clear (new round).
- card_valid  in  1  card presented.
- card  in  CARD_W  rank code (1=Ace … FACE_MAX).
- card_ready  out  1  block can accept a card this cycle.
- total  out  CARD_W  registered hand score modulo MOD.
- card_count  out  $clog2(MAX_CARDS+1)  cards accepted this hand.
- hand_full  out  1  card_count == MAX_CARDS.
- natural  out  1  card_count==2 and total>=NAT_MIN.
- card_err  out  1  one-cycle pulse: invalid code presented while ready.

Behaviour:
- Reset (reset=1 at an edge):
  - total=0, card_count=0, state=EMPTY, card_err=0.
  - card_ready=1, hand_full=0, natural=0.
  - reset overrides clear and card_valid, including mid-hand.
- Card value mapping:
  - codes 1..FACE_MIN-1 score their code value reduced mod MOD (for default MOD=10, code 10 scores 0).
  - codes FACE_MIN..FACE_MAX score FACE_VAL.
  - code 0 and codes >FACE_MAX are invalid.
- Accept: card_valid && card_ready && code valid at an edge.
  - total <= (total + val) mod MOD, computed as a single conditional subtract (total and val are both <MOD), no divider.
  - card_count increments by 1.
  - Latency 1: new total visible the cycle after acceptance.
- Invalid card: card_valid && card_ready && code invalid at an edge.
  - card_err=1 for exactly the next cycle.
  - total and count are unchanged.
  - card_err is otherwise 0.
- States: EMPTY (count 0), PARTIAL (1..MAX_CARDS-1), FULL (count MAX_CARDS).
  - EMPTY→PARTIAL on the first accept.
  - PARTIAL→FULL on the accept that makes count MAX_CARDS.
  - any state→EMPTY on clear.
- Ready and outputs:
  - card_ready = (state != FULL) && !clear. It is combinational from state and clear; it never depends on card_valid.
  - hand_full and natural are decoded from registered state only (glitch-free, no path from card inputs).
- Full hand: card_valid while FULL is ignored. No error, no state change; the card is simply not consumed.
- Clear: clear=1 at an edge zeroes total, card_count and card_err and goes to EMPTY.
  - clear with card_valid in the same cycle: clear wins, the card is not accepted (card_ready was already 0).
- Holding card_valid high across cycles with a valid code accepts one card per cycle until FULL. The controller must drop valid after each intended card.
- No wrap of card_count beyond MAX_CARDS under any input sequence.

Test Plan:
- Reset then cards 9, 13 (K), 5 on consecutive cycles:
  - totals after each edge are 9, 9, 4.
  - card_count 1, 2, 3.
  - natural=1 after the 2nd card.
  - hand_full=1 and card_ready=0 after the 3rd.
- From FULL, present card 7 for 3 cycles → total stays 4, count stays 3, card_err stays 0. Then clear=1 → next cycle total=0, count=0, card_ready=1.
- Present codes 0, 14, 15 from EMPTY → card_err pulses one cycle each, total=0, count=0. Then card 12 (Q) → total 0, count 1, no error.
- Cards 6 and 7 → total 3, natural=0. Then clear and card 9 asserted in the same cycle → next cycle total=0, count=0 (card dropped).
- Cards 4, 4 → natural=1 (total 8). Assert reset mid-hand with card_valid=1 and card 5 → next cycle all outputs at reset values, card not counted.
- Parameter sweep MAX_CARDS=5, MOD=10, FACE_VAL=0, NAT_MIN=8:
  - cards 9,9,9,9,9 give totals 9,8,7,6,5.
  - hand_full only after the 5th card.
  - natural=1 only while count==2.

Source files
------------

// File: rtl/hand_score_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hand_score_accumulator                                     |
// | Description : Accepts one card per valid/ready handshake into a hand of  |
// |               up to MAX_CARDS cards and keeps a registered running total |
// |               reduced modulo MOD. Reports the card count, a full-hand    |
// |               flag, a two-card "natural" flag and a one-cycle pulse for  |
// |               invalid card codes.                                        |
// | Ports       : clk        - system clock, all state on rising edge        |
// |               reset      - synchronous active-high reset                 |
// |               clear      - synchronous hand clear (new round)            |
// |               card_valid - a card is presented                           |
// |               card       - rank code (1 = Ace .. FACE_MAX)               |
// |               card_ready - a card can be accepted this cycle             |
// |               total      - registered hand score modulo MOD              |
// |               card_count - cards accepted in this hand                   |
// |               hand_full  - card_count == MAX_CARDS                       |
// |               natural    - two cards held and total >= NAT_MIN           |
// |               card_err   - pulse: invalid code was presented while ready |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hand_score_accumulator #(
    parameter int MAX_CARDS = 3,
    parameter int CARD_W    = 4,
    parameter int MOD       = 10,
    parameter int FACE_MIN  = 11,
    parameter int FACE_MAX  = 13,
    parameter int FACE_VAL  = 0,
    parameter int NAT_MIN   = 8
) (
    input  wire logic                           clk,
    input  wire logic                           reset,
    input  wire logic                           clear,
    input  wire logic                           card_valid,
    input  wire logic [CARD_W-1:0]              card,
    output logic                                card_ready,
    output logic [CARD_W-1:0]                   total,
    output logic [$clog2(MAX_CARDS+1)-1:0]      card_count,
    output logic                                hand_full,
    output logic                                natural,
    output logic                                card_err
);

    localparam int CNT_W = $clog2(MAX_CARDS + 1);

    // Hand state encoding
    localparam logic [1:0] c_st_empty   = 2'd0;
    localparam logic [1:0] c_st_partial = 2'd1;
    localparam logic [1:0] c_st_full    = 2'd2;

    // Constants widened by one bit so comparisons never overflow the code width
    localparam logic [CARD_W:0]  c_face_min = FACE_MIN[CARD_W:0];
    localparam logic [CARD_W:0]  c_face_max = FACE_MAX[CARD_W:0];
    localparam logic [CARD_W:0]  c_mod      = MOD[CARD_W:0];
    localparam logic [CARD_W:0]  c_nat_min  = NAT_MIN[CARD_W:0];
    localparam logic [CARD_W-1:0] c_face_val = FACE_VAL[CARD_W-1:0];
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(MAX_CARDS - 1);
    localparam logic [CNT_W-1:0] c_two      = CNT_W'(2);

    logic [1:0]        r_state;
    logic [CARD_W-1:0] r_total;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    logic              w_ready;
    logic              w_code_ok;
    logic              w_is_face;
    logic [CARD_W-1:0] w_val;
    logic [CARD_W:0]   w_sum;
    logic [CARD_W-1:0] w_next_total;

    // Ready depends only on registered state and clear, never on card_valid
    assign w_ready = (r_state != c_st_full) && !clear;

    always_comb begin
        w_code_ok = (card != '0) && ({1'b0, card} <= c_face_max);
        w_is_face = ({1'b0, card} >= c_face_min);
        // Pip cards reduce by a constant modulus; face cards score a fixed value
        if (w_is_face) begin
            w_val = c_face_val;
        end else begin
            w_val = CARD_W'(32'(card) % MOD);
        end
        // Both operands are below MOD, so one conditional subtract suffices
        w_sum = {1'b0, r_total} + {1'b0, w_val};
        if (w_sum >= c_mod) begin
            w_next_total = CARD_W'(w_sum - c_mod);
        end else begin
            w_next_total = w_sum[CARD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_empty;
            r_total <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_state <= c_st_empty;
            r_total <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (card_valid && w_ready) begin
                if (w_code_ok) begin
                    r_total <= w_next_total;
                    r_count <= r_count + CNT_W'(1);
                    // The count can only reach MAX_CARDS through this branch,
                    // and FULL blocks further accepts, so it never wraps
                    if (r_count == c_last_cnt) begin
                        r_state <= c_st_full;
                    end else begin
                        r_state <= c_st_partial;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign card_ready = w_ready;
    assign total      = r_total;
    assign card_count = r_count;
    assign card_err   = r_err;
    assign hand_full  = (r_state == c_st_full);
    assign natural    = (r_count == c_two) && ({1'b0, r_total} >= c_nat_min);

endmodule
`default_nettype wire
